// File: rtl/nv_ram_rwsthp_param.sv
// Parametrised 1R1W synchronous RAM with write mask, optional write forwarding,
// per-entry written-valid tracking, registered output with valid, and power-down.
module nv_ram_rwsthp_param #(
  parameter int unsigned DEPTH  = 80,
  parameter int unsigned WIDTH  = 36,
  parameter int unsigned AW     = 7,
  parameter int unsigned LANE_W = 9,
  parameter int unsigned FWD    = 0,
  localparam int unsigned NL    = WIDTH / LANE_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [AW-1:0]    ra,
  input  logic             re,
  input  logic             ore,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic [AW-1:0]    wa,
  input  logic             we,
  input  logic [NL-1:0]    wmask,
  input  logic [WIDTH-1:0] di,
  input  logic             byp_sel,
  input  logic [WIDTH-1:0] dbyp,
  output logic             err_oor,
  input  logic [31:0]      pwrbus_ram_pd
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic             rd_v1_q, rd_v1_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic             err_oor_q, err_oor_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  logic             pd_c;
  logic             unused_pd_c;
  logic             wa_ok_c, ra_ok_c, rd_ok_c;
  logic             wr_en_c;
  logic [AW-1:0]    wa_idx_c, rd_idx_c;
  logic [WIDTH-1:0] wbits_c;
  logic [WIDTH-1:0] mem_wdata_c;
  logic [WIDTH-1:0] mem_rd_c;
  logic             fwd_hit_c;
  logic [WIDTH-1:0] s1_c;

  assign pd_c        = pwrbus_ram_pd[0];
  assign unused_pd_c = ^pwrbus_ram_pd[31:1];

  // Address range checks and clamped array indices
  assign wa_ok_c  = ({1'b0, wa} < DEPTH_C);
  assign ra_ok_c  = ({1'b0, ra} < DEPTH_C);
  assign rd_ok_c  = ({1'b0, rd_addr_q} < DEPTH_C);
  assign wa_idx_c = wa_ok_c ? wa : '0;
  assign rd_idx_c = rd_ok_c ? rd_addr_q : '0;
  assign wr_en_c  = we & ~pd_c & wa_ok_c;

  // Expand the lane mask to a bit mask
  always_comb begin
    wbits_c = '0;
    for (int i = 0; i < int'(NL); i++) begin
      wbits_c[i*LANE_W +: LANE_W] = {LANE_W{wmask[i]}};
    end
  end

  assign mem_wdata_c = (mem_q[wa_idx_c] & ~wbits_c) | (di & wbits_c);

  // Storage array: masked write, no reset
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wa_idx_c] <= mem_wdata_c;
    end
  end

  // Stage-1 read: unwritten or out-of-range entries read as zero
  always_comb begin
    mem_rd_c  = '0;
    if (rd_ok_c && valid_q[rd_idx_c]) begin
      mem_rd_c = mem_q[rd_idx_c];
    end
    fwd_hit_c = (FWD != 0) && wr_en_c && (wa == rd_addr_q);
    if (byp_sel) begin
      s1_c = dbyp;
    end else if (fwd_hit_c) begin
      s1_c = (mem_rd_c & ~wbits_c) | (di & wbits_c);
    end else begin
      s1_c = mem_rd_c;
    end
  end

  // Next-state for pipeline, valid tracking and error flag
  always_comb begin
    rd_addr_d  = rd_addr_q;
    rd_v1_d    = re;
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    err_oor_d  = err_oor_q | (re & ~ra_ok_c) | (we & ~wa_ok_c);
    valid_d    = valid_q;
    if (re) begin
      rd_addr_d = ra;
    end
    if (ore) begin
      dout_d     = s1_c;
      dout_vld_d = rd_v1_q | byp_sel;
    end
    if (pd_c) begin
      valid_d = '0;
    end else if (wr_en_c) begin
      valid_d[wa_idx_c] = 1'b1;
    end
  end

  // Control state registers with async reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_addr_q  <= '0;
      rd_v1_q    <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      err_oor_q  <= 1'b0;
      valid_q    <= '0;
    end else begin
      rd_addr_q  <= rd_addr_d;
      rd_v1_q    <= rd_v1_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      err_oor_q  <= err_oor_d;
      valid_q    <= valid_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign err_oor  = err_oor_q;

endmodule
